semi_parallel_neuron: RTL and testbench

SEMI_PARALLEL_NEURON -- requirements
Module: semi_parallel_neuron

---
 rtl/semi_parallel_neuron_if.sv | 26 ++
 rtl/semi_parallel_neuron.sv | 113 +++++++++++
 tb/tb_semi_parallel_neuron.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/semi_parallel_neuron_if.sv
// rtl/semi_parallel_neuron_if.sv - Operand/result handshake bundle for semi_parallel_neuron
interface semi_parallel_neuron_if #(
  parameter int N  = 8,
  parameter int QW = 16,
  parameter int WW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [N*QW-1:0] in_data;
  logic [N*WW-1:0] weights;
  logic [QW-1:0]   bias;
  logic [1:0]      act_sel;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   out_data;

  modport master (
    output in_valid, in_data, weights, bias, act_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, weights, bias, act_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/semi_parallel_neuron.sv
// rtl/semi_parallel_neuron.sv - Neuron with P-lane MAC over N/P beats, activation and saturation
module semi_parallel_neuron #(
  parameter int N  = 8,
  parameter int P  = 2,
  parameter int QM = 6,
  parameter int QN = 10,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  semi_parallel_neuron_if.slave bus
);
  localparam int QW    = QM + QN;
  localparam int WW    = WM + WN;
  localparam int PW    = QW + WW;
  localparam int AW    = QW + WW + $clog2(N) + 1;
  localparam int BEATS = N / P;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                 state;
  logic [BW-1:0]          beat;
  logic signed [AW-1:0]   acc;
  logic [N*QW-1:0]        in_r;
  logic [N*WW-1:0]        w_r;
  logic [1:0]             act_r;
  logic [QW-1:0]          out_r;
  logic                   in_ready_r;
  logic                   out_valid_r;

  logic signed [AW-1:0]   bias_ext;
  logic signed [PW-1:0]   prod [P];
  logic signed [AW-1:0]   beat_sum;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW-1:0]   shifted;
  logic signed [AW-1:0]   act;
  logic [QW-1:0]          result;
  logic                   in_range;

  assign bias_ext = {{(AW-QW){bus.bias[QW-1]}}, bus.bias};

  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < P; j++) begin
      prod[j]  = $signed(in_r[(beat*P+j)*QW +: QW]) * $signed(w_r[(beat*P+j)*WW +: WW]);
      beat_sum = beat_sum + {{(AW-PW){prod[j][PW-1]}}, prod[j]};
    end
  end

  // Result path sees the final beat already added, so out_data lands on the OUT-entry edge.
  assign acc_sum = acc + beat_sum;
  assign shifted = acc_sum >>> WN;

  always_comb begin
    act = shifted;
    case (act_r)
      2'd1:    if (shifted < 0) act = '0;
      2'd2:    if (shifted < 0) act = shifted >>> 3;
      default: act = shifted;
    endcase
  end

  assign in_range = (&act[AW-1:QW-1]) || ~(|act[AW-1:QW-1]);
  assign result   = in_range ? act[QW-1:0] : {act[AW-1], {(QW-1){~act[AW-1]}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      acc         <= '0;
      in_r        <= '0;
      w_r         <= '0;
      act_r       <= '0;
      out_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          in_r       <= bus.in_data;
          w_r        <= bus.weights;
          act_r      <= bus.act_sel;
          acc        <= bias_ext <<< WN;
          beat       <= '0;
          in_ready_r <= 1'b0;
          state      <= ACCUM;
        end
        ACCUM: begin
          acc  <= acc_sum;
          beat <= beat + BW'(1);
          if (beat == LAST) begin
            out_r       <= result;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_r;
endmodule

// File: tb/tb_semi_parallel_neuron.sv
// tb/tb_semi_parallel_neuron.sv - Directed and randomized checks of semi_parallel_neuron
module tb_semi_parallel_neuron;
  localparam int N  = 8;
  localparam int QW = 16;
  localparam int WW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  semi_parallel_neuron_if #(.N(N), .QW(QW), .WW(WW)) bus ();

  semi_parallel_neuron #(.N(8), .P(2), .QM(6), .QN(10), .WM(6), .WN(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int iv [N];
  int wv [N];
  int res, lat, expv;
  int exp_act [3] = '{-4096, 0, -512};

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expected);
    n_cmp++;
    assert (obs === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expected);
    end
  endtask

  task automatic uniform(input int i, input int w);
    for (int k = 0; k < N; k++) begin
      iv[k] = i;
      wv[k] = w;
    end
  endtask

  task automatic load(input int b, input int a);
    for (int k = 0; k < N; k++) begin
      bus.in_data[k*QW +: QW] = QW'(iv[k]);
      bus.weights[k*WW +: WW] = WW'(wv[k]);
    end
    bus.bias    = QW'(b);
    bus.act_sel = 2'(a);
  endtask

  // Real-valued reference: Q6.10 * Q6.10 products, floor to Q6.10, activation, clamp.
  function automatic int model(input int b, input int a);
    real x, v;
    x = real'(b) / 1024.0;
    for (int k = 0; k < N; k++)
      x = x + (real'(iv[k]) / 1024.0) * (real'(wv[k]) / 1024.0);
    v = $floor(x * 1024.0);
    if (a == 1 && v < 0.0) v = 0.0;
    else if (a == 2 && v < 0.0) v = $floor(v / 8.0);
    if (v > 32767.0) v = 32767.0;
    if (v < -32768.0) v = -32768.0;
    return $rtoi(v);
  endfunction

  // Latency counts edges from the accepting edge (inclusive) to the one raising out_valid.
  task automatic do_txn(input int hold, input bit rnd_ready, output int r, output int l);
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.weights  = {$urandom, $urandom, $urandom, $urandom};
    bus.bias     = 16'($urandom);
    bus.act_sel  = 2'($urandom);
    l = 1;
    while (!bus.out_valid && l < 20) begin
      if (rnd_ready) bus.out_ready = 1'($urandom);
      @(negedge clk);
      l++;
    end
    r = $signed(bus.out_data);
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("hold_data_stable", $signed(bus.out_data), r);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic signed [15:0] t;
    int b, a;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data   = '0;
    bus.weights   = '0;
    bus.bias      = '0;
    bus.act_sel   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", $signed(bus.out_data), 0);
    rst = 1'b0;

    uniform(1024, 512);
    load(0, 0);
    do_txn(0, 0, res, lat);
    check("basic_data", res, 4096);
    check("basic_latency", lat, 5);

    uniform(1024, -512);
    for (int k = 0; k < 3; k++) begin
      load(0, k);
      do_txn(0, 0, res, lat);
      check($sformatf("act%0d_data", k), res, exp_act[k]);
    end

    uniform(32767, 32767);
    load(32767, 0);
    do_txn(0, 0, res, lat);
    check("sat_pos", res, 32767);
    uniform(32767, -32768);
    load(32767, 0);
    do_txn(0, 0, res, lat);
    check("sat_neg", res, -32768);

    uniform(1024, 512);
    load(0, 0);
    do_txn(3, 0, res, lat);
    check("bp_data", res, 4096);
    @(negedge clk);
    check("bp_out_valid_after", bus.out_valid, 0);
    check("bp_in_ready_after", bus.in_ready, 1);
    @(negedge clk);
    check("bp_not_queued", bus.in_ready, 1);

    uniform(1024, 512);
    load(0, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out_data", $signed(bus.out_data), 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    load(0, 0);
    do_txn(0, 0, res, lat);
    check("after_rst_data", res, 4096);

    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < N; k++) begin
        t = 16'($urandom);
        iv[k] = ($urandom_range(0, 3) == 0) ? int'(t) : int'($urandom_range(0, 4095)) - 2048;
        t = 16'($urandom);
        wv[k] = ($urandom_range(0, 3) == 0) ? int'(t) : int'($urandom_range(0, 4095)) - 2048;
      end
      t = 16'($urandom);
      b = int'(t);
      a = int'($urandom_range(0, 3));
      load(b, a);
      expv = model(b, a);
      do_txn(int'($urandom_range(0, 2)), 1'b1, res, lat);
      check($sformatf("rnd%0d_act%0d_data", n, a), res, expv);
      check("rnd_latency", lat, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
